pdm_decimator: RTL

- Receive-side counterpart of the PDM modulator.
- Generates the bit clock for a PDM MEMS microphone and samples its 1-bit data stream.
- Low-pass filters and decimates the stream with a 3rd-order CIC filter.
- Emits NBITS-wide unsigned offset-binary PCM samples with a one-cycle valid strobe. The output format matches the modulator's input, so the two blocks loop back directly.

---
 rtl/pdm_decimator.sv | 93 +++++++++
 1 files changed

// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM mic clock generator and 3rd-order CIC decimator to offset-binary PCM.
module pdm_decimator #(
    parameter int NBITS   = 16,
    parameter int CLK_DIV = 32,
    parameter int DECIM   = 64
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             pdm_in,
    output logic             pdm_clk_out,
    output logic [NBITS-1:0] sample_out,
    output logic             sample_valid_out
);
    localparam int W  = 3 * $clog2(DECIM);
    localparam int CW = $clog2(CLK_DIV);
    localparam int DW = $clog2(DECIM);
    localparam logic [CW-1:0] HALF    = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST    = CW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DLAST   = DW'(DECIM - 1);
    typedef logic [W:0] acc_t;
    logic [CW-1:0] div_q, div_d;
    logic [DW-1:0] dec_q, dec_d;
    logic [1:0] warm_q, warm_d;
    logic [2:0] v_q, v_d;
    acc_t i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    acc_t c1_q, c1_d, c2_q, c2_d, c3;
    acc_t d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [W-1:0] sat;
    logic pdm_clk_q, pdm_clk_d, valid_q, valid_d, bit_stb, dec_stb, emit;
    logic [NBITS-1:0] sample_q, sample_d;
    always_comb begin
        bit_stb   = div_q == HALF_M1;
        dec_stb   = bit_stb && dec_q == DLAST;
        div_d     = div_q == LAST ? '0 : div_q + 1'b1;
        pdm_clk_d = div_q < HALF;
        dec_d     = bit_stb ? dec_q + 1'b1 : dec_q;
        i1_d      = bit_stb ? i1_q + acc_t'(pdm_in) : i1_q;
        i2_d      = bit_stb ? i2_q + i1_q : i2_q;
        i3_d      = bit_stb ? i3_q + i2_q : i3_q;
        v_d       = {v_q[1:0], dec_stb};
        // Each comb stage and its delay advance only while a sample passes through.
        c1_d      = v_q[0] ? i3_q - d1_q : c1_q;
        d1_d      = v_q[0] ? i3_q : d1_q;
        c2_d      = v_q[1] ? c1_q - d2_q : c2_q;
        d2_d      = v_q[1] ? c1_q : d2_q;
        c3        = c2_q - d3_q;
        d3_d      = v_q[2] ? c2_q : d3_q;
        sat       = c3[W] ? '1 : c3[W-1:0];
        emit      = v_q[2] && warm_q == 2'd3;
        warm_d    = v_q[2] && warm_q != 2'd3 ? warm_q + 2'd1 : warm_q;
        sample_d  = emit ? sat[W-1 -: NBITS] : sample_q;
        valid_d   = emit;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_q     <= '0;
            dec_q     <= '0;
            warm_q    <= '0;
            v_q       <= '0;
            i1_q      <= '0;
            i2_q      <= '0;
            i3_q      <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            pdm_clk_q <= 1'b0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            div_q     <= div_d;
            dec_q     <= dec_d;
            warm_q    <= warm_d;
            v_q       <= v_d;
            i1_q      <= i1_d;
            i2_q      <= i2_d;
            i3_q      <= i3_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
            pdm_clk_q <= pdm_clk_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
        end
    end
    assign pdm_clk_out      = pdm_clk_q;
    assign sample_out       = sample_q;
    assign sample_valid_out = valid_q;
endmodule
